// File: rtl/mad_share_arbiter.sv
// Shares one in-order MAD unit between REQ_CNT requesters: round-robin issue,
// tag FIFO of granted indices to steer each returning result to its owner.
module mad_share_arbiter #(
   parameter int REQ_CNT = 4,
   parameter int WIDTH   = 64,
   parameter int DEPTH   = 4
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [REQ_CNT-1:0]       REQ_VALID,
   output logic [REQ_CNT-1:0]       REQ_READY,
   input  logic [REQ_CNT*WIDTH-1:0] REQ_A,
   input  logic [REQ_CNT*WIDTH-1:0] REQ_B,
   input  logic [REQ_CNT*WIDTH-1:0] REQ_C,
   output logic [REQ_CNT-1:0]       RSP_VALID,
   output logic [WIDTH-1:0]         RSP_DATA,
   output logic                     MAD_IE,
   input  logic                     MAD_IREADY,
   output logic [WIDTH-1:0]         MAD_A,
   output logic [WIDTH-1:0]         MAD_B,
   output logic [WIDTH-1:0]         MAD_C,
   input  logic                     MAD_OE,
   input  logic [WIDTH-1:0]         MAD_O,
   output logic                     ERR
);
   localparam int TAG_W = $clog2(REQ_CNT);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] op_a [REQ_CNT];
   logic [WIDTH-1:0] op_b [REQ_CNT];
   logic [WIDTH-1:0] op_c [REQ_CNT];

   for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_unpack
      assign op_a[gi] = REQ_A[gi*WIDTH +: WIDTH];
      assign op_b[gi] = REQ_B[gi*WIDTH +: WIDTH];
      assign op_c[gi] = REQ_C[gi*WIDTH +: WIDTH];
   end

   logic [TAG_W-1:0] last_grant, gnt_idx, cand;
   logic             gnt_found, full, accept, pop;
   logic [CNT_W-1:0] cnt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [WIDTH-1:0] hold_a, hold_b, hold_c;

   // Round-robin search starting just after the last granted index.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = last_grant;
      cand      = last_grant;
      for (int k = 1; k <= REQ_CNT; k++) begin
         cand = TAG_W'((int'(last_grant) + k) % REQ_CNT);
         if (!gnt_found && REQ_VALID[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Full blocks issue even if a pop happens this cycle; nRST gates the
   // combinational strobes so nothing leaks out while reset is held.
   assign full   = (cnt == CNT_W'(DEPTH));
   assign accept = nRST && gnt_found && MAD_IREADY && !full;
   assign pop    = MAD_OE && (cnt != '0);

   always_comb begin
      REQ_READY = '0;
      if (accept) REQ_READY[gnt_idx] = 1'b1;
      RSP_VALID = '0;
      if (pop) RSP_VALID[tag_mem[rd_ptr]] = 1'b1;
   end

   assign MAD_IE   = accept;
   assign MAD_A    = accept ? op_a[gnt_idx] : hold_a;
   assign MAD_B    = accept ? op_b[gnt_idx] : hold_b;
   assign MAD_C    = accept ? op_c[gnt_idx] : hold_c;
   assign RSP_DATA = pop ? MAD_O : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         last_grant <= TAG_W'(REQ_CNT - 1);
         cnt        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         hold_a     <= '0;
         hold_b     <= '0;
         hold_c     <= '0;
         ERR        <= 1'b0;
      end else begin
         if (accept) begin
            last_grant <= gnt_idx;
            hold_a     <= op_a[gnt_idx];
            hold_b     <= op_b[gnt_idx];
            hold_c     <= op_c[gnt_idx];
            wr_ptr     <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         if (accept && !pop)
            cnt <= cnt + CNT_W'(1);
         else if (!accept && pop)
            cnt <= cnt - CNT_W'(1);
         // A result with nothing outstanding is a protocol error; sticky.
         if (MAD_OE && (cnt == '0))
            ERR <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) tag_mem[wr_ptr] <= gnt_idx;
   end

endmodule

// File: tb/tb_mad_share_arbiter.sv
// Randomised and directed checks of mad_share_arbiter against a queue-based
// model of the grant rules, tag ordering and a fixed-latency MAD unit.
module tb_mad_share_arbiter;
   localparam int N = 4;
   localparam int W = 64;
   localparam int D = 4;

   logic           CLK = 1'b0;
   logic           nRST;
   logic [N-1:0]   REQ_VALID, REQ_READY, RSP_VALID;
   logic [N*W-1:0] REQ_A, REQ_B, REQ_C;
   logic [W-1:0]   RSP_DATA, MAD_A, MAD_B, MAD_C, MAD_O;
   logic           MAD_IE, MAD_IREADY, MAD_OE, ERR;

   mad_share_arbiter #(.REQ_CNT(N), .WIDTH(W), .DEPTH(D)) dut (
      .CLK(CLK), .nRST(nRST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C(REQ_C), .RSP_VALID(RSP_VALID),
      .RSP_DATA(RSP_DATA), .MAD_IE(MAD_IE), .MAD_IREADY(MAD_IREADY),
      .MAD_A(MAD_A), .MAD_B(MAD_B), .MAD_C(MAD_C), .MAD_OE(MAD_OE),
      .MAD_O(MAD_O), .ERR(ERR));

   always #5 CLK = ~CLK;

   typedef struct { int due; logic [W-1:0] v; } res_t;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, last_g, lat;
   int tq[$];
   res_t pipe[$];
   logic [W-1:0] ra[N], rb[N], rc[N], ha, hb, hc;
   bit rv[N];
   bit ir, spur, hit, err_m;
   int e_gnt;
   bit e_pop;
   logic [N-1:0] e_ready, e_rv;
   logic [W-1:0] e_rd, e_ma, e_mb, e_mc;

   function automatic logic [W-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Drive this cycle's inputs and derive what the block should present.
   task automatic eval();
      for (int i = 0; i < N; i++) begin
         REQ_VALID[i] = rv[i];
         REQ_A[i*W +: W] = ra[i];
         REQ_B[i*W +: W] = rb[i];
         REQ_C[i*W +: W] = rc[i];
      end
      MAD_IREADY = ir;
      hit    = (pipe.size() > 0) && (pipe[0].due == cyc);
      MAD_OE = hit || spur;
      MAD_O  = hit ? pipe[0].v : rnd64();
      e_gnt = -1;
      if (ir && tq.size() < D)
         for (int k = 1; k <= N; k++)
            if (e_gnt < 0 && rv[(last_g + k) % N]) e_gnt = (last_g + k) % N;
      e_pop   = MAD_OE && (tq.size() > 0);
      e_ready = '0;
      if (e_gnt >= 0) e_ready[e_gnt] = 1'b1;
      e_rv = '0;
      if (e_pop) e_rv[tq[0]] = 1'b1;
      e_rd = MAD_O;
      e_ma = (e_gnt >= 0) ? ra[e_gnt] : ha;
      e_mb = (e_gnt >= 0) ? rb[e_gnt] : hb;
      e_mc = (e_gnt >= 0) ? rc[e_gnt] : hc;
   endtask

   task automatic tick();
      res_t r;
      @(posedge CLK);
      if (MAD_OE && tq.size() == 0) err_m = 1'b1;
      if (e_pop) void'(tq.pop_front());
      if (hit) void'(pipe.pop_front());
      if (e_gnt >= 0) begin
         tq.push_back(e_gnt);
         last_g = e_gnt;
         ha = ra[e_gnt]; hb = rb[e_gnt]; hc = rc[e_gnt];
         r.due = cyc + lat;
         r.v   = ra[e_gnt] * rb[e_gnt] + rc[e_gnt];
         pipe.push_back(r);
         rv[e_gnt] = 1'b0;
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      REQ_VALID = '0; MAD_OE = 1'b0; MAD_IREADY = 1'b0;
      for (int i = 0; i < N; i++) rv[i] = 1'b0;
      ir = 1'b0; spur = 1'b0;
      tq.delete(); pipe.delete();
      last_g = N - 1; err_m = 1'b0; ha = '0; hb = '0; hc = '0;
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic arm(input int i);
      rv[i] = 1'b1; ra[i] = rnd64(); rb[i] = rnd64(); rc[i] = rnd64();
   endtask

   task automatic test_reset();
      @(negedge CLK);
      nRST = 1'b0;
      REQ_VALID = '1; MAD_IREADY = 1'b1; MAD_OE = 1'b1; MAD_O = rnd64();
      REQ_A = {rnd64(), rnd64(), rnd64(), rnd64()};
      REQ_B = REQ_A; REQ_C = REQ_A;
      #2;
      n_cmp++; if (REQ_READY !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", REQ_READY); end
      n_cmp++; if (RSP_VALID !== '0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); end
      n_cmp++; if (MAD_IE !== 1'b0) begin n_bad++; $display("FAIL reset_ie: got %b want 0", MAD_IE); end
      n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", ERR); end
      n_cmp++; if (RSP_DATA !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", RSP_DATA); end
      n_cmp++; if ((MAD_A | MAD_B | MAD_C) !== '0) begin n_bad++; $display("FAIL reset_mad_ops: got %h/%h/%h want 0", MAD_A, MAD_B, MAD_C); end
      do_reset();
   endtask

   task automatic test_single();
      int ies = 0;
      do_reset();
      lat = 3; ir = 1'b1;
      rv[0] = 1'b1; ra[0] = 64'd3; rb[0] = 64'd4; rc[0] = 64'd5;
      for (int i = 0; i < 6; i++) begin
         eval();
         @(negedge CLK);
         if (MAD_IE === 1'b1) ies++;
         if (i == 0) begin
            n_cmp++; if (MAD_A !== 64'd3 || MAD_B !== 64'd4 || MAD_C !== 64'd5) begin n_bad++; $display("FAIL single_ops: got %0d/%0d/%0d want 3/4/5", MAD_A, MAD_B, MAD_C); end
         end
         n_cmp++; if (RSP_VALID !== ((i == 3) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL single_rsp_valid c%0d: got %b", i, RSP_VALID); end
         if (i == 3) begin
            n_cmp++; if (RSP_DATA !== 64'd17) begin n_bad++; $display("FAIL single_rsp_data: got %0d want 17", RSP_DATA); end
         end
         tick();
      end
      n_cmp++; if (ies != 1) begin n_bad++; $display("FAIL single_ie_pulses: got %0d want 1", ies); end
   endtask

   task automatic test_round_robin();
      do_reset();
      lat = 2; ir = 1'b1;
      for (int i = 0; i < 12; i++) begin
         for (int j = 0; j < N; j++) if (!rv[j]) arm(j);
         eval();
         @(negedge CLK);
         n_cmp++; if (REQ_READY !== 4'(1 << (i % N))) begin n_bad++; $display("FAIL rr_grant c%0d: got %b want %b", i, REQ_READY, 4'(1 << (i % N))); end
         n_cmp++; if (RSP_VALID !== ((i >= 2) ? 4'(1 << ((i - 2) % N)) : 4'b0)) begin n_bad++; $display("FAIL rr_route c%0d: got %b", i, RSP_VALID); end
         if (i >= 2) begin
            n_cmp++; if (RSP_DATA !== e_rd) begin n_bad++; $display("FAIL rr_data c%0d: got %h want %h", i, RSP_DATA, e_rd); end
         end
         tick();
      end
   endtask

   task automatic test_full_fifo();
      logic [N-1:0] x_rdy [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      logic [N-1:0] x_rv  [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
      do_reset();
      lat = 6; ir = 1'b1;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < N; j++) if (!rv[j]) arm(j);
         eval();
         @(negedge CLK);
         n_cmp++; if (REQ_READY !== x_rdy[i] || MAD_IE !== (x_rdy[i] != 0)) begin n_bad++; $display("FAIL full_ready c%0d: got %b/%b want %b", i, REQ_READY, MAD_IE, x_rdy[i]); end
         n_cmp++; if (RSP_VALID !== x_rv[i]) begin n_bad++; $display("FAIL full_rsp c%0d: got %b want %b", i, RSP_VALID, x_rv[i]); end
         tick();
      end
   endtask

   task automatic test_ready_stall();
      do_reset();
      lat = 2; ir = 1'b0;
      arm(2);
      for (int i = 0; i < 5; i++) begin
         eval();
         @(negedge CLK);
         n_cmp++; if (REQ_READY !== '0 || MAD_IE !== 1'b0) begin n_bad++; $display("FAIL stall_grant c%0d: got %b/%b want 0/0", i, REQ_READY, MAD_IE); end
         tick();
      end
      ir = 1'b1;
      eval();
      @(negedge CLK);
      n_cmp++; if (REQ_READY !== 4'b0100) begin n_bad++; $display("FAIL stall_release: got %b want 0100", REQ_READY); end
      tick();
      arm(0); arm(3);
      eval();
      @(negedge CLK);
      n_cmp++; if (REQ_READY !== 4'b1000) begin n_bad++; $display("FAIL stall_next_rr: got %b want 1000", REQ_READY); end
      tick();
   endtask

   task automatic test_spurious();
      do_reset();
      lat = 2; ir = 1'b1; spur = 1'b1;
      eval();
      @(negedge CLK);
      n_cmp++; if (RSP_VALID !== '0 || ERR !== 1'b0) begin n_bad++; $display("FAIL spur_cycle: got rsp %b err %b want 0/0", RSP_VALID, ERR); end
      tick();
      spur = 1'b0;
      for (int i = 0; i < 4; i++) begin
         arm(1);
         eval();
         @(negedge CLK);
         n_cmp++; if (ERR !== 1'b1) begin n_bad++; $display("FAIL spur_sticky c%0d: got %b want 1", i, ERR); end
         tick();
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      lat = 10; ir = 1'b1;
      arm(1); arm(2); arm(3);
      for (int i = 0; i < 3; i++) begin
         eval();
         @(negedge CLK);
         n_cmp++; if (REQ_READY !== 4'(2 << i)) begin n_bad++; $display("FAIL mid_issue c%0d: got %b want %b", i, REQ_READY, 4'(2 << i)); end
         tick();
      end
      @(negedge CLK);
      nRST = 1'b0;
      REQ_VALID = '1; MAD_OE = 1'b1;
      #2;
      n_cmp++; if ({REQ_READY, RSP_VALID, MAD_IE, ERR} !== '0 || RSP_DATA !== '0 || MAD_A !== '0) begin n_bad++; $display("FAIL mid_reset_outputs: got %b %b %b %b %h %h", REQ_READY, RSP_VALID, MAD_IE, ERR, RSP_DATA, MAD_A); end
      do_reset();
      lat = 10; ir = 1'b1; spur = 1'b1;
      for (int j = 0; j < N; j++) arm(j);
      eval();
      @(negedge CLK);
      n_cmp++; if (REQ_READY !== 4'b0001 || RSP_VALID !== '0) begin n_bad++; $display("FAIL mid_after_reset: got ready %b rsp %b want 0001/0000", REQ_READY, RSP_VALID); end
      tick();
      spur = 1'b0;
      eval();
      @(negedge CLK);
      n_cmp++; if (ERR !== 1'b1) begin n_bad++; $display("FAIL mid_fifo_cleared: got err %b want 1", ERR); end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      lat = $urandom_range(1, 7);
      for (int i = 0; i < 400; i++) begin
         for (int j = 0; j < N; j++) if (!rv[j] && $urandom_range(0, 1)) arm(j);
         ir = ($urandom_range(0, 3) != 0);
         eval();
         @(negedge CLK);
         n_cmp++; if (REQ_READY !== e_ready || MAD_IE !== (e_gnt >= 0)) begin n_bad++; $display("FAIL rnd_grant c%0d: got %b/%b want %b", i, REQ_READY, MAD_IE, e_ready); end
         n_cmp++; if (MAD_A !== e_ma || MAD_B !== e_mb || MAD_C !== e_mc) begin n_bad++; $display("FAIL rnd_ops c%0d: got %h/%h/%h want %h/%h/%h", i, MAD_A, MAD_B, MAD_C, e_ma, e_mb, e_mc); end
         n_cmp++; if (RSP_VALID !== e_rv) begin n_bad++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", i, RSP_VALID, e_rv); end
         if (e_pop) begin
            n_cmp++; if (RSP_DATA !== e_rd) begin n_bad++; $display("FAIL rnd_rsp_data c%0d: got %h want %h", i, RSP_DATA, e_rd); end
         end
         n_cmp++; if (ERR !== err_m) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", i, ERR, err_m); end
         tick();
      end
   endtask

   initial begin
      nRST = 1'b0;
      REQ_VALID = '0; REQ_A = '0; REQ_B = '0; REQ_C = '0;
      MAD_IREADY = 1'b0; MAD_OE = 1'b0; MAD_O = '0;
      for (int i = 0; i < N; i++) begin rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rc[i] = '0; end
      ir = 1'b0; spur = 1'b0; lat = 1;
      test_reset();
      test_single();
      test_round_robin();
      test_full_fifo();
      test_ready_stall();
      test_spurious();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
